dot_product_engine: RTL and testbench
=====================================

// Module: dot_product_engine
// PURPOSE
//  Parametrised multi-lane signed MAC engine for the dense classifier layer.
//  Computes one weight-matrix row dotted with the stored pixel vector, or all rows back-to-back.
//  Streams both vectors from synchronous RAMs and writes one ACC_W result per row to the result store.
//  Adds signed weights, guard-bit overflow detection, selectable saturation, batch mode and row-index tagging.
// PARAMETERS
//  LANES     2    pixel/weight pairs consumed per beat
//  PIX_W     8    pixel width, unsigned
//  WGT_W     16   weight width, signed two's complement
//  ACC_W     32   result width, signed
//  GUARD_W   8    extra internal accumulator bits; must cover the exact worst-case sum
//  VEC_LEN   784  elements per row; must be a multiple of LANES; BEATS = VEC_LEN/LANES
//  NUM_ROWS  10   rows in the weight matrix
//  PIX_AW    10   pixel RAM address width
//  WGT_AW    12   weight RAM address width
// PORTS
//  clk           in   1              system clock
//  rst           in   1              asynchronous reset, active-high
//  begin_mult    in   1              start request, sampled in IDLE only
//  row_select    in   4              row to compute in single mode; ignored in batch mode
//  all_rows      in   1              1 = batch mode: rows 0..NUM_ROWS-1; sampled with begin_mult
//  sat_en        in   1              1 = saturate result on overflow; sampled with begin_mult
//  pixel_value   in   LANES*PIX_W    RAM data; lane i occupies bits [i*PIX_W +: PIX_W]
//  weight_value  in   LANES*WGT_W    RAM data; lane i occupies bits [i*WGT_W +: WGT_W]
//  pixel_address out  PIX_AW         beat index k
//  weight_address out WGT_AW         row*BEATS + k
//  busy          out  1              high whenever state != IDLE
//  w_result_ena  out  1              one-cycle result-store write strobe
//  done_row      out  1              one-cycle pulse, coincident with w_result_ena
//  row_result    out  ACC_W          signed row result; holds until the next write
//  result_row    out  4              row index of row_result
//  overflow      out  1              row_result was out of signed ACC_W range; updated with each write
//  bad_row       out  1              one-cycle pulse: single-mode begin with row_select >= NUM_ROWS
// BEHAVIOUR
//  - Reset (asynchronous): state IDLE; every output 0, including both addresses, row_result and result_row.
//  - RAMs have 1-cycle read latency. Data for the address driven in cycle t is valid in cycle t+1.
//  - FSM: IDLE -> FETCH -> DRAIN -> RESULT -> IDLE, or RESULT -> FETCH for the next row in batch mode.
//  - IDLE:
//    - begin_mult=1 with a valid row: capture the mode inputs, clear the accumulator, k=0, go to FETCH.
//    - Invalid row in single mode: pulse bad_row and stay in IDLE.
//  - FETCH: BEATS cycles. Drive addresses for k = 0..BEATS-1, one beat per cycle, with no gaps.
//  - Pipeline: data register -> product register -> accumulate.
//    - Each lane product is unsigned pixel x signed weight, kept at full precision.
//    - The lane products are summed, then sign-extended to ACC_W+GUARD_W bits.
//  - DRAIN: 2 cycles to flush the pipeline. Addresses hold their last value.
//  - RESULT: 1 cycle. w_result_ena=1, done_row=1, result_row=current row, and row_result/overflow become valid.
//    - overflow=1 if the exact sum is outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//    - sat_en=1: row_result is clamped to the nearest bound.
//    - sat_en=0: row_result is the low ACC_W bits of the exact sum.
//  - Latency: done_row is asserted BEATS+3 cycles after the clock edge that samples begin_mult.
//  - Batch mode: row r+1 starts FETCH in the cycle after row r's RESULT. No result is dropped.
//  - begin_mult while busy is ignored. A held begin_mult starts exactly one job per IDLE visit.
//  - rst mid-job aborts immediately: no write strobe, and all outputs return to reset values.
// TESTING
//  1 All pixels 1, all weights 1, row 0, single mode -> row_result=784, overflow=0, result_row=0, one w_result_ena.
//  2 Lane-1 weights 0, lane-0 weights 1, row 1 -> 392; weight_address runs 392..783.
//  3 Pixels 1, weights 0xFFFF (-1) -> row_result=0xFFFFFCF0 (-784), overflow=0.
//  4 Pixels 0xFF, weights 0x7FFF:
//    - sat_en=1 -> row_result=0x7FFFFFFF, overflow=1.
//    - sat_en=0 -> row_result=0x8674F310, overflow=1.
//  5 Batch mode, all ones -> 10 done_row pulses spaced BEATS+3 cycles apart.
//    - result_row runs 0..9, each result is 784, weight_address covers 0..3919, then busy drops.
//  6 rst asserted mid-FETCH then released -> outputs 0, no strobe; begin with row_select=12 -> bad_row pulse, busy stays 0.

Source files
------------

// File: rtl/dot_product_engine_if.sv
// Bundle of the MAC engine's control, RAM-read and result-store signals.
// The engine connects through the slave modport; the driver/RAM side uses master.
interface dot_product_engine_if #(
    parameter int LANES  = 2,
    parameter int PIX_W  = 8,
    parameter int WGT_W  = 16,
    parameter int ACC_W  = 32,
    parameter int PIX_AW = 10,
    parameter int WGT_AW = 12
);
    logic                     begin_mult;
    logic [3:0]               row_select;
    logic                     all_rows;
    logic                     sat_en;
    logic [LANES*PIX_W-1:0]   pixel_value;
    logic [LANES*WGT_W-1:0]   weight_value;
    logic [PIX_AW-1:0]        pixel_address;
    logic [WGT_AW-1:0]        weight_address;
    logic                     busy;
    logic                     w_result_ena;
    logic                     done_row;
    logic [ACC_W-1:0]         row_result;
    logic [3:0]               result_row;
    logic                     overflow;
    logic                     bad_row;

    modport master (
        output begin_mult, row_select, all_rows, sat_en, pixel_value, weight_value,
        input  pixel_address, weight_address, busy, w_result_ena, done_row,
               row_result, result_row, overflow, bad_row
    );

    modport slave (
        input  begin_mult, row_select, all_rows, sat_en, pixel_value, weight_value,
        output pixel_address, weight_address, busy, w_result_ena, done_row,
               row_result, result_row, overflow, bad_row
    );
endinterface

// File: rtl/dot_product_engine.sv
// Multi-lane signed MAC engine: streams pixel and weight-row vectors from 1-cycle RAMs,
// accumulates with guard bits and writes one (optionally saturated) result per row.
module dot_product_engine #(
    parameter int LANES    = 2,
    parameter int PIX_W    = 8,
    parameter int WGT_W    = 16,
    parameter int ACC_W    = 32,
    parameter int GUARD_W  = 8,
    parameter int VEC_LEN  = 784,
    parameter int NUM_ROWS = 10,
    parameter int PIX_AW   = 10,
    parameter int WGT_AW   = 12
) (
    input logic                 clk,
    input logic                 rst,
    dot_product_engine_if.slave bus
);
    localparam int BEATS  = VEC_LEN / LANES;
    localparam int SUM_W  = ACC_W + GUARD_W;
    localparam int PROD_W = PIX_W + 1 + WGT_W;
    localparam int PSUM_W = PROD_W + $clog2(LANES);
    localparam logic [3:0]        ROW_LAST  = 4'(NUM_ROWS - 1);
    localparam logic [PIX_AW-1:0] BEAT_LAST = PIX_AW'(BEATS - 1);
    localparam logic signed [SUM_W-1:0] MAX_EXT = {{(GUARD_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_EXT = {{(GUARD_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RESULT} state_t;

    function automatic logic out_of_range(input logic signed [SUM_W-1:0] v);
        return (v > MAX_EXT) || (v < MIN_EXT);
    endfunction

    function automatic logic [ACC_W-1:0] round_result(input logic signed [SUM_W-1:0] v,
                                                      input logic sat);
        logic [ACC_W-1:0] r;
        r = v[ACC_W-1:0];
        if (sat && (v > MAX_EXT)) r = {1'b0, {(ACC_W-1){1'b1}}};
        if (sat && (v < MIN_EXT)) r = {1'b1, {(ACC_W-1){1'b0}}};
        return r;
    endfunction

    state_t                    state, state_next;
    logic [3:0]                row;
    logic                      batch, sat;
    logic                      drain_cnt;
    logic [PIX_AW-1:0]         pix_addr;
    logic [WGT_AW-1:0]         wgt_addr;
    logic                      rd_vld, vld_p0, vld_p1;
    logic [LANES*PIX_W-1:0]    pix_p0;
    logic [LANES*WGT_W-1:0]    wgt_p0;
    logic signed [PSUM_W-1:0]  psum_c, psum_p1;
    logic signed [SUM_W-1:0]   psum_ext, acc, acc_next;
    logic signed [PIX_W:0]     pix_s;
    logic signed [WGT_W-1:0]   wgt_s;
    logic signed [PROD_W-1:0]  prod;
    logic                      row_ok, start, reject, last_beat, next_row_go;
    logic [3:0]                start_row;
    logic [WGT_AW-1:0]         start_wgt;
    logic                      w_ena, bad_row_q, ovf_q;
    logic [ACC_W-1:0]          result_q;
    logic [3:0]                result_row_q;

    always_comb begin
        row_ok      = bus.all_rows || (bus.row_select <= ROW_LAST);
        start       = (state == IDLE) && bus.begin_mult && row_ok;
        reject      = (state == IDLE) && bus.begin_mult && !row_ok;
        last_beat   = (pix_addr == BEAT_LAST);
        next_row_go = (state == RESULT) && batch && (row != ROW_LAST);
        start_row   = bus.all_rows ? 4'd0 : bus.row_select;
        start_wgt   = WGT_AW'(int'(start_row) * BEATS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   if (last_beat) state_next = DRAIN;
            DRAIN:   if (drain_cnt) state_next = RESULT;
            RESULT:  state_next = next_row_go ? FETCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row          <= '0;
            batch        <= 1'b0;
            sat          <= 1'b0;
            drain_cnt    <= 1'b0;
            pix_addr     <= '0;
            wgt_addr     <= '0;
            rd_vld       <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            w_ena        <= 1'b0;
            bad_row_q    <= 1'b0;
            ovf_q        <= 1'b0;
            result_q     <= '0;
            result_row_q <= '0;
        end else begin
            rd_vld    <= (state == FETCH);
            vld_p0    <= rd_vld;
            vld_p1    <= vld_p0;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            w_ena     <= (state == RESULT);
            bad_row_q <= reject;
            if (state == RESULT) begin
                result_q     <= round_result(acc_next, sat);
                ovf_q        <= out_of_range(acc_next);
                result_row_q <= row;
            end
            if (start) begin
                row      <= start_row;
                batch    <= bus.all_rows;
                sat      <= bus.sat_en;
                pix_addr <= '0;
                wgt_addr <= start_wgt;
            end else if ((state == FETCH) && !last_beat) begin
                pix_addr <= pix_addr + 1'b1;
                wgt_addr <= wgt_addr + 1'b1;
            end else if (next_row_go) begin
                // Rows are contiguous in weight RAM, so the next row starts one past the last beat
                row      <= row + 4'd1;
                pix_addr <= '0;
                wgt_addr <= wgt_addr + 1'b1;
            end
        end
    end

    // Stage p0 -> p1: full-precision lane products, summed
    always_comb begin
        psum_c = '0;
        pix_s  = '0;
        wgt_s  = '0;
        prod   = '0;
        for (int i = 0; i < LANES; i++) begin
            pix_s  = signed'({1'b0, pix_p0[i*PIX_W +: PIX_W]});
            wgt_s  = signed'(wgt_p0[i*WGT_W +: WGT_W]);
            prod   = pix_s * wgt_s;
            psum_c = psum_c + PSUM_W'(prod);
        end
    end

    // Stage p1 -> accumulator: sign-extend into the guarded width
    always_comb begin
        psum_ext = {{(SUM_W-PSUM_W){psum_p1[PSUM_W-1]}}, psum_p1};
        acc_next = vld_p1 ? acc + psum_ext : acc;
    end

    always_ff @(posedge clk) begin
        pix_p0  <= bus.pixel_value;
        wgt_p0  <= bus.weight_value;
        psum_p1 <= psum_c;
        acc     <= (start || next_row_go) ? '0 : acc_next;
    end

    assign bus.pixel_address  = pix_addr;
    assign bus.weight_address = wgt_addr;
    assign bus.busy           = (state != IDLE);
    assign bus.w_result_ena   = w_ena;
    assign bus.done_row       = w_ena;
    assign bus.row_result     = result_q;
    assign bus.result_row     = result_row_q;
    assign bus.overflow       = ovf_q;
    assign bus.bad_row        = bad_row_q;
endmodule

// File: tb/tb_dot_product_engine.sv
// Randomized self-checking bench for dot_product_engine with RAM models and an
// arithmetic reference model of each row's dot product.
module tb_dot_product_engine;
    localparam int LANES = 2, PIX_W = 8, WGT_W = 16, ACC_W = 32, GUARD_W = 8;
    localparam int VEC_LEN = 784, NUM_ROWS = 10, PIX_AW = 10, WGT_AW = 12;
    localparam int BEATS = VEC_LEN / LANES;
    localparam int ROW_T = BEATS + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dot_product_engine_if #(.LANES(LANES), .PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W),
                            .PIX_AW(PIX_AW), .WGT_AW(WGT_AW)) bus ();

    dot_product_engine #(.LANES(LANES), .PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W),
                         .GUARD_W(GUARD_W), .VEC_LEN(VEC_LEN), .NUM_ROWS(NUM_ROWS),
                         .PIX_AW(PIX_AW), .WGT_AW(WGT_AW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    logic [LANES*PIX_W-1:0] pix_mem [BEATS];
    logic [LANES*WGT_W-1:0] wgt_mem [NUM_ROWS*BEATS];

    always @(posedge clk) begin
        bus.pixel_value  <= (int'(bus.pixel_address) < BEATS) ? pix_mem[bus.pixel_address] : '0;
        bus.weight_value <= (int'(bus.weight_address) < NUM_ROWS*BEATS) ? wgt_mem[bus.weight_address] : '0;
    end

    typedef struct {
        int         row;
        logic [31:0] res;
        logic       ovf;
        logic       done;
        int         cyc;
    } rec_t;

    rec_t res_q[$];
    rec_t mon_r;
    int   vectors = 0, miscompares = 0;
    int   cyc = 0, strobes = 0, bad_pulses = 0;
    int   wmin, wmax;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.w_result_ena) begin
            strobes++;
            mon_r.row  = int'(bus.result_row);
            mon_r.res  = bus.row_result;
            mon_r.ovf  = bus.overflow;
            mon_r.done = bus.done_row;
            mon_r.cyc  = cyc;
            res_q.push_back(mon_r);
        end
        if (bus.bad_row) bad_pulses++;
        if (bus.busy) begin
            if (int'(bus.weight_address) < wmin) wmin = int'(bus.weight_address);
            if (int'(bus.weight_address) > wmax) wmax = int'(bus.weight_address);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ref_row(input int row, input bit sat, output logic [31:0] res, output logic ovf);
        longint s, p, w, maxv, minv;
        logic [LANES*PIX_W-1:0] pw;
        logic [LANES*WGT_W-1:0] ww;
        s = 0;
        for (int i = 0; i < VEC_LEN; i++) begin
            pw = pix_mem[i / LANES];
            ww = wgt_mem[row * BEATS + i / LANES];
            p  = longint'(pw[(i % LANES)*PIX_W +: PIX_W]);
            w  = longint'($signed(ww[(i % LANES)*WGT_W +: WGT_W]));
            s += p * w;
        end
        maxv = (longint'(1) << (ACC_W - 1)) - 1;
        minv = -(longint'(1) << (ACC_W - 1));
        ovf  = (s > maxv) || (s < minv);
        res  = s[31:0];
        if (sat && s > maxv) res = maxv[31:0];
        if (sat && s < minv) res = minv[31:0];
    endtask

    task automatic fill_const(input logic [7:0] pix, input logic [15:0] w0, input logic [15:0] w1);
        for (int b = 0; b < BEATS; b++) pix_mem[b] = {pix, pix};
        for (int a = 0; a < NUM_ROWS*BEATS; a++) wgt_mem[a] = {w1, w0};
    endtask

    task automatic fill_random(input bit big);
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < LANES; l++)
                pix_mem[b][l*PIX_W +: PIX_W] = big ? 8'($urandom_range(255, 192)) : 8'($urandom);
        for (int a = 0; a < NUM_ROWS*BEATS; a++)
            for (int l = 0; l < LANES; l++)
                wgt_mem[a][l*WGT_W +: WGT_W] = big ? 16'($urandom_range(32767, 24576)) : 16'($urandom);
    endtask

    task automatic start_job(input int row, input bit batch, input bit sat, output int c0);
        @(negedge clk);
        res_q.delete();
        strobes = 0;
        wmin = 1 << 30;
        wmax = -1;
        bus.begin_mult = 1'b1;
        bus.row_select = 4'(row);
        bus.all_rows   = batch;
        bus.sat_en     = sat;
        c0 = cyc + 1;
        @(negedge clk);
        bus.begin_mult = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int k;
        k = 0;
        while (res_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (res_q.size() < n) check("result_timeout", 64'(res_q.size()), 64'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("busy_drop", 64'(bus.busy), 64'd0);
    endtask

    task automatic verify(input string tag, input int idx, input int row, input bit sat, input int c_exp);
        logic [31:0] eres;
        logic        eovf;
        ref_row(row, sat, eres, eovf);
        if (idx >= res_q.size()) begin
            check({tag, ".missing"}, 64'(res_q.size()), 64'(idx + 1));
        end else begin
            check({tag, ".row"}, 64'(res_q[idx].row), 64'(row));
            check({tag, ".res"}, 64'(res_q[idx].res), 64'(eres));
            check({tag, ".ovf"}, 64'(res_q[idx].ovf), 64'(eovf));
            check({tag, ".done"}, 64'(res_q[idx].done), 64'd1);
            check({tag, ".lat"}, 64'(res_q[idx].cyc), 64'(c_exp));
        end
    endtask

    task automatic run_single(input string tag, input int row, input bit sat);
        int c0;
        start_job(row, 1'b0, sat, c0);
        wait_results(1, ROW_T + 20);
        wait_idle(20);
        repeat (3) @(negedge clk);
        verify(tag, 0, row, sat, c0 + ROW_T);
        check({tag, ".strobes"}, 64'(strobes), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"},  64'(bus.busy), 64'd0);
        check({tag, ".wena"},  64'(bus.w_result_ena), 64'd0);
        check({tag, ".done"},  64'(bus.done_row), 64'd0);
        check({tag, ".res"},   64'(bus.row_result), 64'd0);
        check({tag, ".rrow"},  64'(bus.result_row), 64'd0);
        check({tag, ".ovf"},   64'(bus.overflow), 64'd0);
        check({tag, ".bad"},   64'(bus.bad_row), 64'd0);
        check({tag, ".paddr"}, 64'(bus.pixel_address), 64'd0);
        check({tag, ".waddr"}, 64'(bus.weight_address), 64'd0);
    endtask

    initial begin
        int c0, busy_seen, r;
        bit s;
        rst = 1'b1;
        bus.begin_mult = 1'b0;
        bus.row_select = '0;
        bus.all_rows   = 1'b0;
        bus.sat_en     = 1'b0;
        wmin = 1 << 30;
        wmax = -1;
        fill_const(8'd1, 16'd1, 16'd1);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // all ones, row 0; a begin pulse mid-job must be ignored
        start_job(0, 1'b0, 1'b0, c0);
        repeat (50) @(negedge clk);
        bus.begin_mult = 1'b1;
        bus.row_select = 4'd5;
        @(negedge clk);
        bus.begin_mult = 1'b0;
        wait_results(1, ROW_T + 20);
        wait_idle(20);
        repeat (3) @(negedge clk);
        check("t1.res_const", 64'(res_q.size() > 0 ? res_q[0].res : 32'hDEAD), 64'd784);
        verify("t1", 0, 0, 1'b0, c0 + ROW_T);
        check("t1.strobes", 64'(strobes), 64'd1);

        fill_const(8'd1, 16'd1, 16'd0);
        run_single("t2", 1, 1'b0);
        check("t2.res_const", 64'(res_q[0].res), 64'd392);
        check("t2.wmin", 64'(wmin), 64'd392);
        check("t2.wmax", 64'(wmax), 64'd783);

        fill_const(8'd1, 16'hFFFF, 16'hFFFF);
        run_single("t3", 2, 1'b0);
        check("t3.res_const", 64'(res_q[0].res), 64'hFFFFFCF0);

        fill_const(8'hFF, 16'h7FFF, 16'h7FFF);
        run_single("t4s", 3, 1'b1);
        check("t4s.res_const", 64'(res_q[0].res), 64'h7FFFFFFF);
        check("t4s.ovf_const", 64'(res_q[0].ovf), 64'd1);
        run_single("t4w", 9, 1'b0);
        check("t4w.res_const", 64'(res_q[0].res), 64'h8674F310);
        fill_const(8'hFF, 16'h8000, 16'h8000);
        run_single("t4n", 4, 1'b1);
        check("t4n.res_const", 64'(res_q[0].res), 64'h80000000);

        // batch mode; row_select=12 must be ignored rather than rejected
        fill_const(8'd1, 16'd1, 16'd1);
        bad_pulses = 0;
        start_job(12, 1'b1, 1'b0, c0);
        wait_results(NUM_ROWS, NUM_ROWS*ROW_T + 50);
        wait_idle(20);
        for (int i = 0; i < NUM_ROWS; i++) verify($sformatf("t5.r%0d", i), i, i, 1'b0, c0 + (i+1)*ROW_T);
        check("t5.strobes", 64'(strobes), 64'(NUM_ROWS));
        check("t5.wmin", 64'(wmin), 64'd0);
        check("t5.wmax", 64'(wmax), 64'd3919);
        check("t5.bad", 64'(bad_pulses), 64'd0);

        // reset mid-FETCH, then a rejected row
        start_job(0, 1'b0, 1'b0, c0);
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("t6.rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (ROW_T + 20) @(negedge clk);
        check("t6.no_strobe", 64'(strobes), 64'd0);
        check_reset_outputs("t6.after");
        bad_pulses = 0;
        start_job(12, 1'b0, 1'b0, c0);
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy) busy_seen++;
            @(negedge clk);
        end
        check("t6.bad_pulse", 64'(bad_pulses), 64'd1);
        check("t6.busy", 64'(busy_seen), 64'd0);
        run_single("t6.recover", 7, 1'b0);

        // randomized vectors, small and overflow-prone
        for (int t = 0; t < 6; t++) begin
            fill_random(t >= 4);
            r = int'($urandom_range(NUM_ROWS - 1, 0));
            s = 1'($urandom);
            run_single($sformatf("rnd%0d", t), r, s);
        end
        fill_random(1'b0);
        s = 1'($urandom);
        start_job(0, 1'b1, s, c0);
        wait_results(NUM_ROWS, NUM_ROWS*ROW_T + 50);
        wait_idle(20);
        for (int i = 0; i < NUM_ROWS; i++) verify($sformatf("rndb.r%0d", i), i, i, s, c0 + (i+1)*ROW_T);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
